// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory controller: funct3 access codes,
// controller FSM states and the request legality rule.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} mem_state_t;

   // Size/sign code must exist for the operation and the address must be
   // naturally aligned to the access size. Unsigned variants are loads only.
   function automatic logic is_legal(input logic [2:0] f3,
                                     input logic [1:0] a,
                                     input logic       is_store);
      logic ok;
      case (f3)
         F3_B:         ok = 1'b1;
         F3_H:         ok = ~a[0];
         F3_W:         ok = (a == 2'b00);
         F3_BU:        ok = ~is_store;
         F3_HU:        ok = ~is_store & ~a[0];
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering between the 32-bit array word and the core: builds the
// store byte enables and replicated write word, and extracts/extends loads.
module dmem_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] ldata
);

   logic [7:0]  lb;
   logic [15:0] lh;

   // Store path: replicate the datum across lanes, enable only the target bytes.
   always_comb begin
      be    = 4'b1111;
      wword = wdata;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
         end
         2'b01: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load path: pick the addressed byte/half and extend per funct3.
   always_comb begin
      lb = rword[8*lane +: 8];
      lh = lane[1] ? rword[31:16] : rword[15:0];
      case (funct3)
         F3_B:    ldata = {{24{lb[7]}}, lb};
         F3_H:    ldata = {{16{lh[15]}}, lh};
         F3_BU:   ldata = {24'd0, lb};
         F3_HU:   ldata = {16'd0, lh};
         default: ldata = rword;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store from the decoder, inserts
// WAIT_STATES idle cycles, performs the array access and pulses done while
// holding the pipeline with stall.
module dmem_ctrl
   import riscv_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        MemRead,
   input  logic        MemWr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);
   localparam mem_state_t FIRST    = (WAIT_STATES == 0) ? ACCESS : WAIT;

   mem_state_t     state, nxt;
   logic [3:0]     cnt;
   logic [AW+1:0]  a_q;
   logic [31:0]    wd_q;
   logic [2:0]     f3_q;
   logic           st_q;

   logic           req, legal, accept;
   logic [3:0]     be;
   logic [31:0]    wword, ldata, rword;
   logic           unused_addr;

   logic [31:0]    mem [DEPTH_WORDS];

   // Upper address bits alias onto the array.
   assign unused_addr = ^addr[31:AW+2];

   assign req    = MemRead | MemWr;
   assign legal  = is_legal(funct3, addr[1:0], MemWr) & ~(MemRead & MemWr);
   assign accept = (state == IDLE) & req & legal;
   assign rword  = mem[a_q[AW+1:2]];

   dmem_align u_align (
      .funct3 (f3_q),
      .lane   (a_q[1:0]),
      .wdata  (wd_q),
      .rword  (rword),
      .be     (be),
      .wword  (wword),
      .ldata  (ldata)
   );

   // Next-state and handshake outputs; stall/err are forced low during reset.
   always_comb begin
      nxt   = state;
      stall = 1'b0;
      err   = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (legal) begin
                  nxt   = FIRST;
                  stall = 1'b1;
               end else begin
                  err   = 1'b1;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (cnt == 4'd1) nxt = ACCESS;
         end
         ACCESS: begin
            stall = 1'b1;
            nxt   = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
      stall = stall & n_rst;
      err   = err & n_rst;
   end

   // State, wait counter, request latch and load result register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         a_q   <= '0;
         wd_q  <= 32'd0;
         f3_q  <= 3'd0;
         st_q  <= 1'b0;
         rdata <= 32'd0;
      end else begin
         state <= nxt;
         if (accept) begin
            a_q  <= addr[AW+1:0];
            wd_q <= wdata;
            f3_q <= funct3;
            st_q <= MemWr;
            cnt  <= CNT_INIT;
         end else if (state == WAIT) begin
            cnt  <= cnt - 4'd1;
         end
         if (state == ACCESS && !st_q) rdata <= ldata;
      end
   end

   // Array write; reset drops the FSM out of ACCESS so no write lands.
   always_ff @(posedge clk) begin
      if (state == ACCESS && st_q && n_rst) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[a_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: two controllers (one wait state / 1024 words, no wait
// states / 64 words) checked against a byte-addressed reference memory.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        n_rst [2];
   logic        mr    [2];
   logic        mw    [2];
   logic [2:0]  f3    [2];
   logic [31:0] ad    [2];
   logic [31:0] wd    [2];
   logic [31:0] rd    [2];
   logic        st    [2];
   logic        dn    [2];
   logic        er    [2];

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  mref  [2][4096];
   logic [31:0] exp_rd[2];

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u0 (
      .clk(clk), .n_rst(n_rst[0]), .MemRead(mr[0]), .MemWr(mw[0]),
      .funct3(f3[0]), .addr(ad[0]), .wdata(wd[0]),
      .rdata(rd[0]), .stall(st[0]), .done(dn[0]), .err(er[0]));

   dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u1 (
      .clk(clk), .n_rst(n_rst[1]), .MemRead(mr[1]), .MemWr(mw[1]),
      .funct3(f3[1]), .addr(ad[1]), .wdata(wd[1]),
      .rdata(rd[1]), .stall(st[1]), .done(dn[1]), .err(er[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int wstates(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   function automatic int msize(input int d);
      return (d == 0) ? 4096 : 256;
   endfunction

   function automatic int asize(input logic [2:0] f);
      return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit ref_legal(input bit r, input bit w, input logic [2:0] f,
                                    input logic [31:0] a);
      bit okf;
      if (r && !w)      okf = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
      else if (w && !r) okf = (f == 0 || f == 1 || f == 2);
      else              okf = 0;
      return okf && ((a % asize(f)) == 0);
   endfunction

   function automatic logic [31:0] ref_load(input int d, input logic [2:0] f,
                                            input logic [31:0] a);
      int n = asize(f);
      logic [31:0] v = 0;
      for (int i = 0; i < n; i++) v |= 32'(mref[d][(a + i) % msize(d)]) << (8 * i);
      if (f == 3'b000 && v[7])  v |= 32'hFFFFFF00;
      if (f == 3'b001 && v[15]) v |= 32'hFFFF0000;
      return v;
   endfunction

   task automatic ref_store(input int d, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] w);
      for (int i = 0; i < asize(f); i++) mref[d][(a + i) % msize(d)] = w[8*i +: 8];
   endtask

   // One request starting in an IDLE cycle; follows it to completion.
   task automatic xact(input int d, input bit r, input bit w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] v, input bit scramble,
                       input string tag);
      bit ok = ref_legal(r, w, f, a);
      int lat = wstates(d) + 2;
      @(negedge clk);
      mr[d] = r; mw[d] = w; f3[d] = f; ad[d] = a; wd[d] = v;
      #1;
      chk({tag, ".err0"}, er[d], !ok);
      chk({tag, ".stall0"}, st[d], ok);
      if (!ok) begin
         @(negedge clk);
         mr[d] = 0; mw[d] = 0;
         for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk({tag, ".nodone"}, dn[d], 0);
            chk({tag, ".rdkeep"}, rd[d], exp_rd[d]);
         end
         return;
      end
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) begin
            mr[d] = 0; mw[d] = 0;
            if (scramble) begin
               f3[d] = 3'($urandom); ad[d] = $urandom; wd[d] = $urandom;
            end
         end
         #1;
         chk({tag, ".stall"}, st[d], (k <= lat - 1));
         chk({tag, ".done"}, dn[d], (k == lat));
      end
      if (w) ref_store(d, f, a, v);
      else   exp_rd[d] = ref_load(d, f, a);
      chk({tag, ".rdata"}, rd[d], exp_rd[d]);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         n_rst[d] = 0; mr[d] = 0; mw[d] = 0; f3[d] = 0; ad[d] = 0; wd[d] = 0;
         exp_rd[d] = 0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         mr[d] = 1; mw[d] = 1;
         #1;
         chk("rst.stall", st[d], 0);
         chk("rst.err", er[d], 0);
         chk("rst.done", dn[d], 0);
         chk("rst.rdata", rd[d], 0);
         mr[d] = 0; mw[d] = 0;
      end
      @(negedge clk);
      n_rst[0] = 1; n_rst[1] = 1;

      // Known contents for the test window of both arrays.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++) xact(d, 0, 1, 3'b010, 32'(4 * i), 0, 0, "init");

      // Directed cases on the one-wait-state controller.
      xact(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10");
      xact(0, 1, 0, 3'b010, 32'h10, 0, 0, "lw10");
      chk("lw10.val", rd[0], 32'hDEADBEEF);
      xact(0, 0, 1, 3'b010, 32'h10, 0, 0, "sw10z");
      xact(0, 0, 1, 3'b000, 32'h11, 32'h80, 1, "sb11");
      xact(0, 1, 0, 3'b000, 32'h11, 0, 1, "lb11");
      chk("lb11.val", rd[0], 32'hFFFFFF80);
      xact(0, 1, 0, 3'b100, 32'h11, 0, 1, "lbu11");
      chk("lbu11.val", rd[0], 32'h00000080);
      xact(0, 1, 0, 3'b010, 32'h10, 0, 1, "lw10b");
      chk("lw10b.val", rd[0], 32'h00008000);
      xact(0, 0, 1, 3'b001, 32'h22, 32'h8001, 1, "sh22");
      xact(0, 1, 0, 3'b001, 32'h22, 0, 1, "lh22");
      chk("lh22.val", rd[0], 32'hFFFF8001);
      xact(0, 1, 0, 3'b101, 32'h22, 0, 1, "lhu22");
      chk("lhu22.val", rd[0], 32'h00008001);
      xact(0, 1, 0, 3'b001, 32'h20, 0, 1, "lh20");
      chk("lh20.val", rd[0], 32'h00000000);

      // Illegal requests leave array and rdata untouched.
      xact(0, 1, 0, 3'b010, 32'h13, 0, 0, "ill.lw13");
      xact(0, 0, 1, 3'b001, 32'h01, 32'hFFFF, 0, "ill.sh01");
      xact(0, 1, 0, 3'b011, 32'h10, 0, 0, "ill.f3");
      xact(0, 1, 1, 3'b010, 32'h10, 32'h0BADF00D, 0, "ill.both");
      xact(0, 0, 1, 3'b100, 32'h10, 32'h0BADF00D, 0, "ill.sbu");
      xact(0, 1, 0, 3'b010, 32'h10, 0, 0, "ill.lw10");
      chk("ill.lw10.val", rd[0], 32'h00008000);
      xact(0, 1, 0, 3'b010, 32'h20, 0, 0, "ill.lw20");
      chk("ill.lw20.val", rd[0], 32'h80010000);

      // Reset during WAIT cancels a store.
      xact(0, 0, 1, 3'b010, 32'h40, 32'h12345678, 0, "sw40");
      @(negedge clk);
      mw[0] = 1; f3[0] = 3'b010; ad[0] = 32'h40; wd[0] = 32'hCAFEF00D;
      @(negedge clk);
      n_rst[0] = 0; mr[0] = 1; mw[0] = 1;
      #1;
      chk("rstw.stall", st[0], 0);
      chk("rstw.done", dn[0], 0);
      chk("rstw.err", er[0], 0);
      chk("rstw.rdata", rd[0], 0);
      exp_rd[0] = 0;
      mr[0] = 0; mw[0] = 0;
      @(negedge clk);
      n_rst[0] = 1;
      xact(0, 1, 0, 3'b010, 32'h40, 0, 0, "lw40");
      chk("lw40.val", rd[0], 32'h12345678);

      // Zero-wait controller: latency and back-to-back loads held high.
      xact(1, 0, 1, 3'b010, 32'h8, 32'hA5A5_0F0F, 0, "z.sw8");
      xact(1, 1, 0, 3'b010, 32'h8, 0, 0, "z.lw8");
      @(negedge clk);
      mr[1] = 1; f3[1] = 3'b010; ad[1] = 32'h8;
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 5) mr[1] = 0;
         #1;
         chk("b2b.stall", st[1], (k == 0 || k == 1 || k == 3 || k == 4));
         chk("b2b.done", dn[1], (k == 2 || k == 5));
         if (k == 2 || k == 5) chk("b2b.rdata", rd[1], 32'hA5A5_0F0F);
      end
      xact(1, 1, 0, 3'b000, 32'h100 + 32'h9, 0, 0, "z.alias");

      // Randomized traffic, including illegal encodings and aliased addresses.
      for (int n = 0; n < 150; n++) begin
         int d = n % 2;
         logic [31:0] a = $urandom_range(0, 127);
         logic [31:0] hi = (d == 0) ? ($urandom & 32'hFFFFF000) : ($urandom & 32'hFFFFFF00);
         int op = $urandom_range(0, 9);
         bit r = (op < 5) || (op == 9);
         bit w = (op >= 5);
         xact(d, r, w, 3'($urandom), a | hi, $urandom, 1, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
